// File: rtl/bin2bcd_pkg.sv
// rtl/bin2bcd_pkg.sv - shared types and constants for the sequential binary-to-BCD converter
package bin2bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } bin2bcd_state_t;

   localparam logic [3:0] BCD_BLANK   = 4'hF;
   localparam logic [3:0] ADD3_THRESH = 4'd5;

   // Bit counter must hold BIN_W itself, not just BIN_W-1.
   function automatic int cnt_width(input int bin_w);
      return $clog2(bin_w + 1);
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - double-dabble per-digit correction: add 3 when the digit is 5 or more
module bcd_digit_adj
   import bin2bcd_pkg::*;
(
   input  logic [3:0] i_digit,
   output logic [3:0] o_digit
);

   assign o_digit = (i_digit >= ADD3_THRESH) ? i_digit + 4'd3 : i_digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-add-3 binary-to-BCD converter; BIN2BCD_LEADING_ZERO_BLANK_EN blanks leading zeros
module bin2bcd_seq
   import bin2bcd_pkg::*;
#(
   parameter int BIN_W  = 12,
   parameter int DIGITS = 4
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  overflow
);

   localparam int SCR_W = 4 * (DIGITS + 1);
   localparam int CNT_W = cnt_width(BIN_W);

   bin2bcd_state_t      r_state;
   bin2bcd_state_t      w_next_state;
   logic [BIN_W-1:0]    r_shift;
   logic [SCR_W-1:0]    r_scr;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_lost;
   logic [4*DIGITS-1:0] r_bcd;
   logic                r_ovf;

   logic [SCR_W-1:0]    w_adj;
   logic [SCR_W-1:0]    w_scr_next;
   logic                w_lost_next;
   logic                w_last;
   logic                w_ovf_next;
   logic [4*DIGITS-1:0] w_bcd_fmt;

   genvar g;
   generate
      for (g = 0; g < DIGITS + 1; g++) begin : g_adj
         bcd_digit_adj u_adj (
            .i_digit (r_scr[4*g +: 4]),
            .o_digit (w_adj[4*g +: 4])
         );
      end
   endgenerate

   assign w_scr_next  = {w_adj[SCR_W-2:0], r_shift[BIN_W-1]};
   // A carry out of the guard digit means the value is far beyond range; keep it sticky.
   assign w_lost_next = r_lost | w_adj[SCR_W-1];
   assign w_last      = (r_cnt == CNT_W'(1));
   assign w_ovf_next  = (w_scr_next[SCR_W-1 -: 4] != 4'd0) | w_lost_next;

`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
   always_comb begin
      logic w_lead;
      w_bcd_fmt = w_scr_next[4*DIGITS-1:0];
      w_lead    = 1'b1;
      for (int d = DIGITS - 1; d >= 1; d--) begin
         if (w_lead && (w_scr_next[4*d +: 4] == 4'd0)) begin
            w_bcd_fmt[4*d +: 4] = BCD_BLANK;
         end else begin
            w_lead = 1'b0;
         end
      end
   end
`else
   assign w_bcd_fmt = w_scr_next[4*DIGITS-1:0];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      busy         = 1'b0;
      done         = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_next_state = SHIFT;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            if (w_last) begin
               w_next_state = DONE;
            end
         end
         DONE: begin
            busy         = 1'b1;
            done         = 1'b1;
            w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   // The result is registered on the final shift edge so it is already valid while done is high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shift <= '0;
         r_scr   <= '0;
         r_cnt   <= '0;
         r_lost  <= 1'b0;
         r_bcd   <= '0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_shift <= bin;
                  r_scr   <= '0;
                  r_cnt   <= CNT_W'(BIN_W);
                  r_lost  <= 1'b0;
               end
            end
            SHIFT: begin
               r_scr   <= w_scr_next;
               r_shift <= r_shift << 1;
               r_cnt   <= r_cnt - CNT_W'(1);
               r_lost  <= w_lost_next;
               if (w_last) begin
                  r_bcd <= w_bcd_fmt;
                  r_ovf <= w_ovf_next;
               end
            end
            default: ;
         endcase
      end
   end

   assign bcd      = r_bcd;
   assign overflow = r_ovf;

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential shift-add-3 (double-dabble) binary-to-BCD converter.
- Sits directly upstream of the 4-digit seven-segment debug display driver.
- Converts a captured binary debug value (address, received byte, counter) into per-digit BCD nibbles. This removes the wide divide/modulo logic from the display path.
- Start/done handshake; output is held stable between conversions so the multiplexed display never shows torn digits.

Parameters:
- BIN_W, 12, width of binary input.
- DIGITS, 4, number of BCD digits presented on the output.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- start  input  1  request conversion of bin; sampled only in IDLE
- bin  input  BIN_W  binary value; captured on the accepted start
- busy  output  1  high from the cycle after start is accepted through the DONE cycle
- done  output  1  one-cycle pulse; bcd and overflow are valid and updated in this cycle
- bcd  output  4*DIGITS  BCD result; digit 0 (ones) is in [3:0], digit DIGITS-1 is in the top nibble
- overflow  output  1  high when the captured value is >= 10^DIGITS; updated with done

Behaviour:
- Reset: clk single clock; rst asynchronous, active-high. While rst is high: state=IDLE, busy=0, done=0, bcd=0, overflow=0, all internal registers cleared.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE, start=1: capture bin into the shift register; clear the scratch BCD register; load bit counter = BIN_W. Go to SHIFT.
  - SHIFT, each cycle: for every scratch digit >= 5, add 3. Then shift {scratch, shift register} left by 1. Decrement the counter. When the counter reaches 1 on this cycle, go to DONE.
  - DONE: register bcd = lower DIGITS scratch digits; overflow = (extra guard digit != 0). Assert done for exactly this cycle. Go to IDLE.
- Scratch register holds DIGITS+1 digits. The guard digit is used only for overflow detection.
- Latency: start accepted at edge 0; done is high during cycle BIN_W+1 (cycle 13 for the defaults).
- Throughput: one conversion per BIN_W+2 cycles. A new start is accepted in IDLE on the cycle after done.
- start during SHIFT or DONE: ignored, not queued.
- bin changing after capture: no effect on the conversion in progress.
- bcd and overflow change only in the DONE cycle. Otherwise they hold their last result indefinitely.
- Reset asserted mid-conversion: the conversion is aborted and no done pulse is produced. The previous bcd is lost (cleared to 0).
- bin = 0: normal BIN_W-cycle conversion; result is all-zero digits.
- No combinational path from any input to any output.

Optional Feature:
- Macro: BIN2BCD_LEADING_ZERO_BLANK_EN
- Defined: when the DONE cycle registers the result, every leading zero digit above the most significant non-zero digit is replaced by 4'hF. The downstream decoder treats 4'hF as blank.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
  - overflow behaviour is unchanged.
- Undefined: all digits are output as plain BCD, with leading zeros shown.

Decomposition:
- Package bin2bcd_pkg contains:
  - state enum (IDLE, SHIFT, DONE)
  - constant BCD_BLANK = 4'hF
  - constant ADD3_THRESH = 4'd5
  - counter-width function clog2(BIN_W+1)
- One natural sub-module: bcd_digit_adj. It is combinational and per-digit: out = (in >= 5) ? in+3 : in. It is instantiated DIGITS+1 times via generate.

Test Plan:
- Reset, then bin=0, start one cycle -> busy high for 13 cycles; done pulses in cycle 13; bcd=16'h0000; overflow=0.
- bin=12'd4095 -> bcd=16'h4095, overflow=0. Then bin=12'd1234 started the cycle after done -> bcd=16'h1234; second done arrives 14 cycles after the first.
- start pulsed again in cycle 5 of a 12'd987 conversion, with bin changed to 12'd111 -> single done; bcd=16'h0987; no second conversion starts.
- rst asserted in cycle 6 of a 12'd2500 conversion -> bcd=0, busy=0, no done pulse. A subsequent start of 12'd42 gives bcd=16'h0042.
- BIN_W=14, DIGITS=4, bin=14'd12345 -> bcd=16'h2345, overflow=1. bin=14'd9999 -> overflow=0.
- With BIN2BCD_LEADING_ZERO_BLANK_EN defined:
  - 12'd7 -> bcd=16'hFFF7
  - 12'd0 -> 16'hFFF0
  - 12'd1005 -> 16'h1005 (interior zeros kept)
